// File: rtl/hack_pc_pkg.sv
// Shared types for the Hack program counter: run/halt state and the
// resolved per-cycle pc operation.
package hack_pc_pkg;

  localparam int unsigned HACK_WORD = 16;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

endpackage

// File: rtl/hack_ret_stack.sv
// LIFO of return addresses. Push on a full stack and pop on an empty stack
// are silently dropped; the owner raises the sticky flags. Contents are not
// reset, only the occupancy level is.
module hack_ret_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_q, level_d;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !pop_i && !full_o;
  assign do_pop  = pop_i && !push_i && !empty_o;
  assign wr_idx  = IDX_W'(level_q);
  assign top_idx = IDX_W'(level_q - LVL_W'(1));
  assign top_o   = mem_q[top_idx];
  assign level_o = level_q;

  // Occupancy follows the accepted push/pop.
  always_comb begin
    level_d = level_q;
    if (do_push) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/hack_pc.sv
// Hack program counter with run/halt control. Priority in RUN:
// halt_req > ret > call > load > inc > hold.
// Optional return-address stack enabled by defining HACK_PC_RETSTACK_EN;
// without it call/ret are ignored and the stack outputs read zero.
module hack_pc
  import hack_pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = HACK_WORD,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int unsigned      STACK_DEPTH = 8,
  localparam int unsigned     LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             running_o,
  output logic [LVL_W-1:0] stack_level_o,
  output logic             stack_ovf_o,
  output logic             stack_unf_o
);

  state_e           state_q, state_d;
  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stk_top;
  logic             stk_empty;

  assign pc_inc    = pc_q + WIDTH'(1);
  assign pc_o      = pc_q;
  assign running_o = (state_q == ST_RUN);

  // Run/halt next state; halt_req always wins over resume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (halt_req_i) state_d = ST_HALT;
      ST_HALT: if (resume_i && !halt_req_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Priority encoder resolving this cycle's pc operation.
  always_comb begin
    op = OP_HOLD;
    if (state_q == ST_RUN && !halt_req_i) begin
`ifdef HACK_PC_RETSTACK_EN
      if (ret_i && call_i) begin
        op = OP_LOAD;  // tail call: jump only, stack untouched
      end else if (ret_i) begin
        op = OP_RET;
      end else if (call_i) begin
        op = OP_CALL;
      end else if (load_i) begin
        op = OP_LOAD;
      end else if (inc_i) begin
        op = OP_INC;
      end
`else
      if (load_i) begin
        op = OP_LOAD;
      end else if (inc_i) begin
        op = OP_INC;
      end
`endif
    end
  end

  // Next pc from the resolved operation.
  always_comb begin
    pc_d = pc_q;
    unique case (op)
      OP_INC:          pc_d = pc_inc;
      OP_LOAD, OP_CALL: pc_d = in_i;
      OP_RET:          pc_d = stk_empty ? pc_inc : stk_top;
      default:         pc_d = pc_q;
    endcase
  end

  // State and pc registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef HACK_PC_RETSTACK_EN
  logic stk_full;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  hack_ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk        (clk),
    .reset      (reset),
    .push_i     (op == OP_CALL),
    .pop_i      (op == OP_RET),
    .push_data_i(pc_inc),
    .top_o      (stk_top),
    .level_o    (stack_level_o),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  // Sticky flags set by a dropped push or an empty pop.
  always_comb begin
    ovf_d = ovf_q | ((op == OP_CALL) && stk_full);
    unf_d = unf_q | ((op == OP_RET) && stk_empty);
  end

  // Flag registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;
`else
  logic unused_stack_ins;

  assign unused_stack_ins = ^{call_i, ret_i};
  assign stk_top          = '0;
  assign stk_empty        = 1'b1;
  assign stack_level_o    = '0;
  assign stack_ovf_o      = 1'b0;
  assign stack_unf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_hack_pc.sv
// Self-checking bench for hack_pc: table-driven vectors, hand sequences for
// multi-cycle stack and reset corners, and random stimulus against a
// queue-based reference model. Stack checks follow HACK_PC_RETSTACK_EN.
module tb_hack_pc;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
`ifdef HACK_PC_RETSTACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             load = 1'b0, inc = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic             call = 1'b0, ret = 1'b0;
  logic [WIDTH-1:0] pc;
  logic             running;
  logic [LVL_W-1:0] level;
  logic             ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  hack_pc #(
    .WIDTH      (WIDTH),
    .RESET_VEC  ('0),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_i         (din),
    .load_i       (load),
    .inc_i        (inc),
    .halt_req_i   (halt_req),
    .resume_i     (resume),
    .call_i       (call),
    .ret_i        (ret),
    .pc_o         (pc),
    .running_o    (running),
    .stack_level_o(level),
    .stack_ovf_o  (ovf),
    .stack_unf_o  (unf)
  );

  always #5 clk = ~clk;

  // Reference model: pc value, halted bit, return addresses in a queue.
  logic [WIDTH-1:0] m_pc;
  bit               m_halt;
  logic [WIDTH-1:0] m_stk[$];
  bit               m_ovf, m_unf;

  function automatic void model_reset();
    m_pc = '0;
    m_halt = 1'b0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step();
    if (m_halt) begin
      if (resume && !halt_req) m_halt = 1'b0;
    end else if (halt_req) begin
      m_halt = 1'b1;
    end else if (EN && call && ret) begin
      m_pc = din;
    end else if (EN && ret) begin
      if (m_stk.size() == 0) begin
        m_pc  = m_pc + 1;
        m_unf = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (EN && call) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back(m_pc + 1);
      m_pc = din;
    end else if (load) begin
      m_pc = din;
    end else if (inc) begin
      m_pc = m_pc + 1;
    end
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, " pc"}, pc, m_pc);
    check({tag, " running"}, running, !m_halt);
    check({tag, " level"}, level, m_stk.size());
    check({tag, " ovf"}, ovf, m_ovf);
    check({tag, " unf"}, unf, m_unf);
  endtask

  task automatic drive(input logic l, input logic i, input logic h, input logic r,
                       input logic c, input logic rt, input logic [WIDTH-1:0] d);
    load = l; inc = i; halt_req = h; resume = r; call = c; ret = rt; din = d;
  endtask

  // Advance one edge; model sees the same inputs the DUT samples.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic             load, inc, halt, resume;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_pc;
    logic             exp_run;
  } vec_t;

  function automatic vec_t mk(input logic l, input logic i, input logic h, input logic r,
                              input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p,
                              input logic run);
    vec_t v;
    v.load = l; v.inc = i; v.halt = h; v.resume = r;
    v.din = d; v.exp_pc = p; v.exp_run = run;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(0, 1, 0, 0, 16'h0000, 16'h0001, 1);
    vecs[1]  = mk(0, 1, 0, 0, 16'h0000, 16'h0002, 1);
    vecs[2]  = mk(0, 1, 0, 0, 16'h0000, 16'h0003, 1);
    vecs[3]  = mk(1, 1, 0, 0, 16'h1234, 16'h1234, 1);
    vecs[4]  = mk(0, 0, 0, 0, 16'h0000, 16'h1234, 1);
    vecs[5]  = mk(1, 0, 0, 0, 16'h0005, 16'h0005, 1);
    vecs[6]  = mk(0, 1, 1, 0, 16'h0000, 16'h0005, 0);
    vecs[7]  = mk(1, 0, 0, 0, 16'h0009, 16'h0005, 0);
    vecs[8]  = mk(0, 0, 1, 1, 16'h0000, 16'h0005, 0);
    vecs[9]  = mk(0, 0, 0, 1, 16'h0000, 16'h0005, 1);
    vecs[10] = mk(0, 1, 0, 0, 16'h0000, 16'h0006, 1);
    vecs[11] = mk(1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1);
    vecs[12] = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1);

    do_reset();
    check("reset pc", pc, 0);
    check("reset running", running, 1);
    check("reset level", level, 0);
    check("reset ovf", ovf, 0);
    check("reset unf", unf, 0);

    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].load, vecs[k].inc, vecs[k].halt, vecs[k].resume, 0, 0, vecs[k].din);
      step();
      check($sformatf("vec%0d pc", k), pc, vecs[k].exp_pc);
      check($sformatf("vec%0d running", k), running, vecs[k].exp_run);
      check($sformatf("vec%0d ovf", k), ovf, 0);
    end

    // Asynchronous reset between edges, from a halted non-zero pc.
    drive(1, 0, 0, 0, 0, 0, 16'h0777);
    step();
    drive(0, 0, 1, 0, 0, 0, '0);
    step();
    check("pre-reset running", running, 0);
    drive(0, 0, 0, 0, 0, 0, '0);
    #3;
    reset = 1'b1;
    #1;
    check("async reset pc", pc, 0);
    check("async reset running", running, 1);
    #2;
    reset = 1'b0;
    model_reset();

`ifdef HACK_PC_RETSTACK_EN
    // Call/return, then underflow and its stickiness.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 16'd10); step();
    drive(0, 0, 0, 0, 1, 0, 16'd100); step();
    check("call pc", pc, 100);
    check("call level", level, 1);
    drive(0, 0, 0, 0, 0, 1, '0); step();
    check("ret pc", pc, 11);
    check("ret level", level, 0);
    drive(0, 0, 0, 0, 0, 1, '0); step();
    check("unf ret pc", pc, 12);
    check("unf set", unf, 1);
    drive(0, 0, 0, 0, 0, 0, '0);
    repeat (5) step();
    check("unf sticky", unf, 1);
    check("unf pc hold", pc, 12);

    // Overflow at depth 2.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 16'd20); step();
    drive(0, 0, 0, 0, 1, 0, 16'd30); step();
    check("ovf clear at full", ovf, 0);
    drive(0, 0, 0, 0, 1, 0, 16'd40); step();
    check("ovf pc", pc, 40);
    check("ovf level", level, 2);
    check("ovf set", ovf, 1);
    drive(0, 0, 0, 0, 0, 1, '0); step();
    check("ovf ret1 pc", pc, 21);
    drive(0, 0, 0, 0, 0, 1, '0); step();
    check("ovf ret2 pc", pc, 1);
    check("ovf ret2 level", level, 0);
    check("ovf no unf", unf, 0);

    // Tail call: call and ret together.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 16'd50); step();
    drive(0, 0, 0, 0, 1, 1, 16'h0200); step();
    check("tail pc", pc, 16'h0200);
    check("tail level", level, 1);
    check("tail ovf", ovf, 0);
    check("tail unf", unf, 0);
`else
    // Without the stack, call/ret are ignored entirely.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 16'h0300); step();
    check("nostk call hold", pc, 0);
    drive(0, 1, 0, 0, 1, 0, 16'h0300); step();
    check("nostk call inc", pc, 1);
    drive(0, 1, 0, 0, 0, 1, '0); step();
    check("nostk ret inc", pc, 2);
    drive(1, 0, 0, 0, 1, 1, 16'h0044); step();
    check("nostk load", pc, 16'h0044);
    check("nostk level", level, 0);
    check("nostk ovf", ovf, 0);
    check("nostk unf", unf, 0);
`endif

    // Random stimulus against the model, with periodic resets.
    do_reset();
    compare_model("rnd reset");
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 199) begin
        do_reset();
        compare_model("rnd reset");
      end
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            WIDTH'($urandom));
      step();
      compare_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
